// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issuer:
//   - ALU operation codes driven on alu_ctrl
//   - bit positions of the fields inside a 13-bit instruction word
//   - the issuer FSM state encoding
//   - a helper that tells legal op codes from illegal ones
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU operation codes; everything above ALU_NOT is illegal
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_NOT = 4'b0100;

   // Instruction word layout: {op, rd, rs, rt}
   localparam int INS_W  = 13;
   localparam int OP_MSB = 12;
   localparam int OP_LSB = 9;
   localparam int RD_MSB = 8;
   localparam int RD_LSB = 6;
   localparam int RS_MSB = 5;
   localparam int RS_LSB = 3;
   localparam int RT_MSB = 2;
   localparam int RT_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ISSUE  = 2'b01,
      ST_CAPT   = 2'b10,
      ST_REPORT = 2'b11
   } state_e;

   // Op codes are contiguous from ADD up to NOT
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= ALU_NOT);
   endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// -----------------------------------------------------------------------------
// alu_issuer_fifo
// Synchronous FIFO holding pending instruction words.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push         write push_data when not full
//   push_data    entry to enqueue
//   pop          remove the head when not empty
//   pop_data     current head entry (valid while !empty)
//   full         registered: no room for another push
//   empty        registered: nothing the reader may pop
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB.  A freshly written entry is exposed to the reader one cycle after its
// write, so a slot is never written and read in the same cycle.
// -----------------------------------------------------------------------------
module alu_issuer_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 13
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         full_q, full_d;
   logic         empty_q, empty_d;
   logic         push_ok_s;
   logic         pop_ok_s;

   assign push_ok_s = push && !full_q;
   assign pop_ok_s  = pop && !empty_q;
   assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign full      = full_q;
   assign empty     = empty_q;

   // Next-state pointers, storage and status flags
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = push_ok_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
      rd_ptr_d = pop_ok_s  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
      end else begin
         mem_d = mem_q;
      end
      full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      // Empty now, or was empty during the cycle just ending
      empty_d = (wr_ptr_d == rd_ptr_d) || (wr_ptr_q == rd_ptr_q);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

endmodule

// File: rtl/alu_issuer.sv
// -----------------------------------------------------------------------------
// alu_issuer
// Command-side initiator for an external 8-bit combinational ALU.  Queues
// instructions, reads operands from an internal 8x8 register file, drives the
// ALU, captures its result, writes it back and reports it on a result port.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ins_valid/ins_ready   instruction handshake, ins_data = {op,rd,rs,rt}
//   wr_en/wr_addr/wr_data host write into the register file
//   alu_ctrl/alu_x/alu_y  registered drive to the ALU
//   alu_out/alu_carry     ALU response
//   res_valid/res_ready   result handshake
//   res_data/res_carry/res_rd/res_err  captured result, destination, error
//   perf_count            completed result handshakes (only with
//                         ALU_ISSUER_PERF_EN defined)
// Optional feature macro: ALU_ISSUER_PERF_EN
// -----------------------------------------------------------------------------
module alu_issuer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int NREG       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ins_valid,
   output logic              ins_ready,
   input  logic [INS_W-1:0]  ins_data,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [3:0]        alu_ctrl,
   output logic [7:0]        alu_x,
   output logic [7:0]        alu_y,
   input  logic [7:0]        alu_out,
   input  logic              alu_carry,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [7:0]        res_data,
   output logic              res_carry,
   output logic [2:0]        res_rd,
   output logic              res_err
`ifdef ALU_ISSUER_PERF_EN
   ,output logic [15:0]      perf_count
`endif
);

   state_e           state_q, state_d;
   logic [INS_W-1:0] instr_q, instr_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic [7:0]       alu_x_q, alu_x_d;
   logic [7:0]       alu_y_q, alu_y_d;
   logic             res_valid_q, res_valid_d;
   logic [7:0]       res_data_q, res_data_d;
   logic             res_carry_q, res_carry_d;
   logic [2:0]       res_rd_q, res_rd_d;
   logic             res_err_q, res_err_d;
   logic [7:0]       rf_q [NREG];
   logic [7:0]       rf_d [NREG];

   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             fifo_pop_s;
   logic [INS_W-1:0] fifo_head_s;
   logic [3:0]       op_s;
   logic [2:0]       rd_s;
   logic [2:0]       rs_s;
   logic [2:0]       rt_s;

   alu_issuer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (INS_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ins_valid),
      .push_data (ins_data),
      .pop       (fifo_pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign op_s = instr_q[OP_MSB:OP_LSB];
   assign rd_s = instr_q[RD_MSB:RD_LSB];
   assign rs_s = instr_q[RS_MSB:RS_LSB];
   assign rt_s = instr_q[RT_MSB:RT_LSB];

   assign ins_ready = !fifo_full_s;
   assign alu_ctrl  = alu_ctrl_q;
   assign alu_x     = alu_x_q;
   assign alu_y     = alu_y_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_rd    = res_rd_q;
   assign res_err   = res_err_q;

   // FSM next state, ALU drive, result capture and register-file writes
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      alu_ctrl_d  = alu_ctrl_q;
      alu_x_d     = alu_x_q;
      alu_y_d     = alu_y_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_rd_d    = res_rd_q;
      res_err_d   = res_err_q;
      fifo_pop_s  = 1'b0;
      rf_d        = rf_q;

      // Host write first so a same-cycle writeback below overrides it
      if (wr_en) begin
         rf_d[wr_addr] = wr_data;
      end else begin
         rf_d = rf_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               instr_d    = fifo_head_s;
               state_d    = ST_ISSUE;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Operands come from rf_q: host writes of this cycle are not seen
            if (op_is_legal(op_s)) begin
               alu_ctrl_d = op_s;
               alu_x_d    = rf_q[rs_s];
               alu_y_d    = (op_s == ALU_NOT) ? 8'h00 : rf_q[rt_s];
               state_d    = ST_CAPT;
            end else begin
               // ALU drive is left untouched; report the error directly
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_data_d  = 8'h00;
               res_carry_d = 1'b0;
               res_rd_d    = rd_s;
               state_d     = ST_REPORT;
            end
         end
         ST_CAPT: begin
            res_valid_d = 1'b1;
            res_err_d   = 1'b0;
            res_data_d  = alu_out;
            res_carry_d = alu_carry;
            res_rd_d    = rd_s;
            rf_d[rd_s]  = alu_out;
            state_d     = ST_REPORT;
         end
         ST_REPORT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_REPORT;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

`ifdef ALU_ISSUER_PERF_EN
   logic [15:0] perf_q, perf_d;

   assign perf_count = perf_q;

   // Count completed result handshakes; wraps naturally at 16 bits
   always_comb begin
      if (res_valid_q && res_ready) begin
         perf_d = perf_q + 16'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Performance counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= 16'h0000;
      end else begin
         perf_q <= perf_d;
      end
   end
`endif

   // FSM, ALU drive, result and register-file state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         alu_ctrl_q  <= 4'h0;
         alu_x_q     <= 8'h00;
         alu_y_q     <= 8'h00;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_carry_q <= 1'b0;
         res_rd_q    <= 3'd0;
         res_err_q   <= 1'b0;
         rf_q        <= '{default: 8'h00};
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         alu_ctrl_q  <= alu_ctrl_d;
         alu_x_q     <= alu_x_d;
         alu_y_q     <= alu_y_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_rd_q    <= res_rd_d;
         res_err_q   <= res_err_d;
         rf_q        <= rf_d;
      end
   end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Command-side companion to the 8-bit combinational ALU. It is the initiator that drives ctrl/x/y and consumes out/carry.
- Accepts encoded instructions through a valid/ready queue and reads operands from an internal 8x8 register file.
- Issues each instruction to the external ALU, captures the result, writes it back to the register file, and reports it on a valid/ready result port.
- Sits between the testbench/host sequencer and the ALU.

Parameters:
- FIFO_DEPTH, 4, instruction queue entries; power of two, minimum 2.
- NREG, 8, register file entries; fixed at 8 because instruction fields are 3 bits.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- ins_valid  in  1  instruction offered.
- ins_ready  out  1  queue not full.
- ins_data  in  13  {op[12:9], rd[8:6], rs[5:3], rt[2:0]}.
- wr_en  in  1  host register write.
- wr_addr  in  3  host write index.
- wr_data  in  8  host write value.
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  8  to ALU x.
- alu_y  out  8  to ALU y.
- alu_out  in  8  from ALU out.
- alu_carry  in  1  from ALU carry.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  8  captured result.
- res_carry  out  1  captured carry.
- res_rd  out  3  destination of the reported result.
- res_err  out  1  op was illegal.

Behaviour:
- Reset values: ins_ready=1, res_valid=0, res_data=0, res_carry=0, res_rd=0, res_err=0, alu_ctrl=0, alu_x=0, alu_y=0. FIFO is emptied, FSM goes to IDLE, all registers clear to 0.
- Op codes: ADD=0000, SUB=0001, AND=0010, OR=0011, NOT=0100 (uses rs only, alu_y=0). Codes 0101..1111 are illegal.
- Enqueue: on ins_valid && ins_ready at an edge. ins_ready = !full. Simultaneous push and pop while full is not allowed; ready is low, so the push does not happen.
- FSM states: IDLE, ISSUE, CAPT, REPORT.
- IDLE: if FIFO is non-empty, pop the head into the instruction register and go to ISSUE.
- ISSUE (1 cycle):
  - alu_ctrl=op, alu_x=rf[rs], alu_y=rf[rt] (0 for NOT), all registered.
  - Illegal op: alu_ctrl/x/y are held at their previous values, and the FSM goes to REPORT with res_err=1, res_data=0, res_carry=0. No writeback.
  - Legal op: go to CAPT.
- CAPT (1 cycle): sample alu_out/alu_carry into res_data/res_carry. Write rf[rd]=alu_out. Set res_valid=1 and res_rd=rd, go to REPORT.
- REPORT: hold all res_* stable while res_valid && !res_ready. On res_ready, clear res_valid and go to IDLE.
- Latency: instruction pushed at edge T reaches res_valid=1 at edge T+4 when the FIFO was empty and the FSM was in IDLE.
- Carry: SUB carry is the raw ALU bit 8 (borrow as 9-bit two's-complement wrap). AND/OR/NOT report the ALU carry as delivered, 0.
- Host write conflict: if wr_en and a CAPT writeback hit the same cycle, the CAPT writeback wins. Different addresses both commit.
- Operand read in ISSUE sees host writes committed at earlier edges only; no same-cycle bypass.
- rd==rs is legal; the read happens before the write.
- FIFO wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from MSB comparison.
- Reset asserted in any state: the next edge returns to reset values, and any in-flight instruction is dropped without writeback.

Optional Feature:
- Macro ALU_ISSUER_PERF_EN.
- When defined: adds port perf_count out 16. It increments once per completed result handshake (res_valid && res_ready), including errors, wraps at 0xFFFF→0, and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - Op-code localparams ALU_ADD/SUB/AND/OR/NOT.
  - Instruction field bit positions.
  - The state encoding for IDLE/ISSUE/CAPT/REPORT.
- One sub-module, alu_issuer_fifo: a parameterised synchronous FIFO with push/pop/full/empty. The register file and FSM stay in the top.

Test Plan:
- Write rf[1]=0xF0, rf[2]=0x20; push ADD rd=3 rs=1 rt=2 → res_data=0x10, res_carry=1, res_rd=3, rf[3]=0x10, res_valid at T+4.
- rf[1]=0x05, rf[2]=0x07; SUB rd=4 → res_data=0xFE, res_carry=1; then OR rd=5 rs=4 rt=2 → 0xFF, carry=0.
- Push 5 instructions back-to-back with res_ready=0 and FIFO_DEPTH=4 → ins_ready drops after the 4th push into a non-draining FIFO. Then raise res_ready → all results arrive in order, none lost.
- Push op=0111 → res_err=1, res_data=0, no register written; the next legal op executes normally.
- CAPT writeback to rd=6 coincides with wr_en addr 6 data 0xAA → rf[6] holds the ALU result. With the macro defined, perf_count counts each handshake.
- Assert reset during CAPT → res_valid=0, rf[rd] unchanged (0), FIFO empty, ins_ready=1 on the next cycle.
